// File: rtl/cpu_mpu_csr.sv
// CSR-side owner of the data MPU: region descriptors, fault capture and trap request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no fault recorded, STAT[0]=0, trap_request low
// S_PENDING | fault captured, trap_request high until trap_ack
// S_HELD    | trap taken, fault record kept until software clears it
module cpu_mpu_csr #(
  parameter int          NUM_REGIONS   = 8,
  parameter logic [31:0] RESET_REGION0 = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        supervisor,
  input  logic        csr_write,
  input  logic        csr_read,
  input  logic [3:0]  csr_sel,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_error,
  input  logic        cpud_request,
  input  logic        cpud_write,
  input  logic [31:0] cpud_addr,
  input  logic        access_deny,
  output logic [31:0] csr_dmpu0,
  output logic [31:0] csr_dmpu1,
  output logic [31:0] csr_dmpu2,
  output logic [31:0] csr_dmpu3,
  output logic [31:0] csr_dmpu4,
  output logic [31:0] csr_dmpu5,
  output logic [31:0] csr_dmpu6,
  output logic [31:0] csr_dmpu7,
  output logic        trap_request,
  input  logic        trap_ack
);

  // Descriptor bits [7:4] are reserved and always stored as zero.
  localparam logic [31:0] DESC_MASK = 32'hFFFF_FF0F;

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_HELD} fault_state_e;

  fault_state_e state_q, state_d;
  logic [31:0]  dmpu_q [NUM_REGIONS];
  logic [31:0]  rdata_q;
  logic         error_q;
  logic         cap_req_q, cap_wr_q;
  logic [31:0]  cap_addr_q;
  logic [31:0]  faddr_q, faddr_d;
  logic         fwr_q, fwr_d;
  logic         ovf_q, ovf_d;

  logic         sup_wr, wr_bad, rd_bad, stat_wr, qual_fault, clear_evt, fvalid;
  logic [31:0]  rd_val;

  assign sup_wr     = csr_write & supervisor;
  assign wr_bad     = csr_write & (~supervisor | (csr_sel == 4'd8) | (csr_sel >= 4'd10));
  assign rd_bad     = csr_read & (~supervisor | (csr_sel >= 4'd10));
  assign stat_wr    = sup_wr & (csr_sel == 4'd9);
  assign qual_fault = access_deny & cap_req_q;
  assign clear_evt  = stat_wr & csr_wdata[0] & (state_q == S_HELD);
  assign fvalid     = (state_q != S_IDLE);

  // Read mux over the pre-write register contents.
  always_comb begin
    rd_val = '0;
    if (!csr_sel[3]) begin
      rd_val = dmpu_q[csr_sel[2:0]];
    end else if (csr_sel == 4'd8) begin
      rd_val = faddr_q;
    end else if (csr_sel == 4'd9) begin
      rd_val = {29'd0, ovf_q, fwr_q, fvalid};
    end
  end

  // Region descriptor storage; only supervisor writes to sel 0-7 land here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dmpu_q[0] <= RESET_REGION0;
      for (int i = 1; i < NUM_REGIONS; i++) dmpu_q[i] <= '0;
    end else if (sup_wr && !csr_sel[3]) begin
      dmpu_q[csr_sel[2:0]] <= csr_wdata & DESC_MASK;
    end
  end

  // Registered read data (held between reads) and one-cycle error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= rd_bad | wr_bad;
      if (csr_read) rdata_q <= rd_bad ? 32'd0 : rd_val;
    end
  end

  // Capture stage pairing a request with the deny verdict one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_req_q  <= 1'b0;
      cap_wr_q   <= 1'b0;
      cap_addr_q <= '0;
    end else begin
      cap_req_q <= cpud_request;
      if (cpud_request) begin
        cap_wr_q   <= cpud_write;
        cap_addr_q <= cpud_addr;
      end
    end
  end

  // Fault FSM state and fault record registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      faddr_q <= '0;
      fwr_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      faddr_q <= faddr_d;
      fwr_q   <= fwr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Fault FSM next state; a fault arriving with a clear-write is captured fresh.
  always_comb begin
    state_d = state_q;
    faddr_d = faddr_q;
    fwr_d   = fwr_q;
    ovf_d   = ovf_q;
    if (stat_wr && csr_wdata[2]) ovf_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (qual_fault) begin
          state_d = S_PENDING;
          faddr_d = cap_addr_q;
          fwr_d   = cap_wr_q;
        end
      end
      S_PENDING: begin
        if (qual_fault) ovf_d = 1'b1;
        if (trap_ack) state_d = S_HELD;
      end
      S_HELD: begin
        if (clear_evt && qual_fault) begin
          state_d = S_PENDING;
          faddr_d = cap_addr_q;
          fwr_d   = cap_wr_q;
        end else if (clear_evt) begin
          state_d = S_IDLE;
          fwr_d   = 1'b0;
        end else if (qual_fault) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign csr_rdata    = rdata_q;
  assign csr_error    = error_q;
  assign trap_request = (state_q == S_PENDING);
  assign csr_dmpu0    = dmpu_q[0];
  assign csr_dmpu1    = dmpu_q[1];
  assign csr_dmpu2    = dmpu_q[2];
  assign csr_dmpu3    = dmpu_q[3];
  assign csr_dmpu4    = dmpu_q[4];
  assign csr_dmpu5    = dmpu_q[5];
  assign csr_dmpu6    = dmpu_q[6];
  assign csr_dmpu7    = dmpu_q[7];

endmodule
